fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one FIFO write port among N producers, using a round-robin policy with a per-grant burst limit.
//  Sits between producer blocks and the FIFO write side (data_in/wr_en in, full/almostfull/wr_ack/overflow out).
//  Beats are throttled on FIFO status, so the FIFO never sees a write while full.
// PARAMETERS
//  N_REQ       4   number of requesters (>=2)
//  FIFO_WIDTH  16  data width, matches the FIFO
//  MAX_BURST   4   max beats per grant before forced rotation (>=1)
// PORTS
//  clk              in   1            single clock, rising edge
//  rst              in   1            synchronous, active-high reset
//  req_valid        in   N_REQ        per-requester beat valid
//  req_data         in   N_REQ*W      per-requester data, slice i = [i*W +: W]
//  req_last         in   N_REQ        last beat of packet, qualifies req_valid
//  req_ready        out  N_REQ        beat accepted when valid&ready
//  fifo_data_in     out  W            registered data to the FIFO
//  fifo_wr_en       out  1            registered write enable to the FIFO
//  fifo_full        in   1            FIFO full
//  fifo_almostfull  in   1            FIFO holds DEPTH-1 entries
//  fifo_wr_ack      in   1            FIFO write accepted (1 cycle after wr_en)
//  fifo_overflow    in   1            FIFO write rejected
//  grant_id         out  $clog2(N)    current owner
//  grant_active     out  1            a grant is held
//  err_overflow     out  1            sticky: fifo_overflow was seen
// BEHAVIOUR
//  Reset outputs:
//   - req_ready=0, fifo_wr_en=0, fifo_data_in=0, grant_id=0, grant_active=0, err_overflow=0.
//   - Internal state: rr_ptr=0, beat_cnt=0, state=IDLE.
//  FSM IDLE:
//   - If no req_valid is asserted, stay in IDLE.
//   - Otherwise pick the first asserted index searching from rr_ptr upward, wrapping.
//   - Latch that index as grant_id, clear beat_cnt, go to BURST.
//  FSM BURST:
//   - req_ready[g] = !fifo_full && !(fifo_almostfull && fifo_wr_en). All other ready bits are 0.
//   - On each accepted beat: fifo_wr_en<=1, fifo_data_in<=slice g, beat_cnt++.
//     The FIFO write is seen one cycle after acceptance.
//   - Go to IDLE on an accepted beat that has req_last=1, or when beat_cnt==MAX_BURST-1.
//     On that exit, rr_ptr <= (g+1) mod N_REQ.
//   - If there is no accepted beat, fifo_wr_en<=0 and the grant is held (no timeout).
//  Grant handover:
//   - There is one IDLE bubble cycle between grants.
//   - Max throughput is MAX_BURST beats per MAX_BURST+1 cycles.
//  Flow-control rules:
//   - A beat is never accepted while fifo_full=1.
//   - The almostfull term covers the in-flight registered write.
//   - req_valid changes mid-burst do not release the grant. Only last or the burst limit releases it.
//   - req_ready is combinational from state and FIFO flags only. It never depends on req_valid.
//  Status outputs:
//   - err_overflow: set by fifo_overflow=1; cleared only by rst.
//   - fifo_wr_ack: monitored only; no retry is performed.
//  Reset mid-burst: the FSM goes to IDLE, the pending write is dropped (fifo_wr_en=0 next cycle), rr_ptr=0.
//  Width rules:
//   - beat_cnt width is $clog2(MAX_BURST)+1.
//   - grant_id and rr_ptr wrap modulo N_REQ; this also holds for non-power-of-2 N_REQ.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//   - Adds output stat_beats (N_REQ*16): per-requester count of accepted beats.
//   - Counters saturate at 16'hFFFF and clear on rst.
//  Undefined: the port is absent and no counter logic is present.
// STRUCTURE
//  fifo_arb_pkg:
//   - typedef enum logic {IDLE, BURST} arb_state_e.
//   - Function for the index width.
//   - Constant STAT_W=16.
//  Sub-module rr_pick (combinational): inputs req[N] and ptr, outputs idx and found. Used in IDLE.
// TESTING  (N_REQ=4, W=16, MAX_BURST=4, FIFO_DEPTH=8)
//  1. rst=1 for 2 cycles with random inputs -> all outputs 0, including after release with no valid.
//  2. Only req 2 valid, data 16'hA000..A002, last on 3rd beat ->
//     grant_id=2, three writes in order, then IDLE, rr_ptr=3.
//  3. All 4 valid, never last ->
//     grants rotate 0,1,2,3,0, each exactly 4 beats, with 1 bubble cycle between grants.
//  4. FIFO not drained while req 0 streams ->
//     exactly 8 writes accepted, req_ready=0 while full, fifo_overflow never set.
//  5. Drain 1 entry while full ->
//     exactly 1 further beat accepted, data order preserved.
//  6. rst asserted mid-burst at beat 2 ->
//     next cycle fifo_wr_en=0, grant_active=0. After release, req 1 and req 3 both valid -> req 1 is granted first.
//     With FIFO_ARB_STATS_EN, stat_beats is 0 after rst.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   STAT_W      : width of each per-requester beat counter (optional stats)
//   idx_w()     : index width needed to address n requesters (min 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: returns the first asserted request
//   found when searching upward from ptr, wrapping modulo N. Works for any
//   N >= 2, including non-power-of-2 counts.
// Ports
//   req   in  [N-1:0]   request vector
//   ptr   in  [IW-1:0]  search start index (always < N)
//   idx   out [IW-1:0]  selected index (0 when nothing found)
//   found out           at least one request asserted
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // One spare bit so ptr+k cannot overflow before the modulo fold.
  logic [IW:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares a single FIFO write port among N_REQ producers. Grants rotate
//   round-robin; each grant lasts until a beat with req_last is accepted or
//   MAX_BURST beats have been accepted. The write to the FIFO is registered,
//   and acceptance is throttled on full/almostfull so the FIFO never sees a
//   write while full.
//
//   Optional feature macro: FIFO_ARB_STATS_EN
//     defined   -> adds stat_beats, per-requester saturating beat counters
//     undefined -> no stat_beats port, no counter logic
//
// Ports
//   clk              in                 clock, rising edge
//   rst              in                 synchronous active-high reset
//   req_valid        in  [N_REQ-1:0]    per-requester beat valid
//   req_data         in  [N_REQ*W-1:0]  per-requester data, slice i = [i*W +: W]
//   req_last         in  [N_REQ-1:0]    last beat of packet
//   req_ready        out [N_REQ-1:0]    beat accepted when valid & ready
//   fifo_data_in     out [W-1:0]        registered FIFO write data
//   fifo_wr_en       out                registered FIFO write enable
//   fifo_full        in                 FIFO full
//   fifo_almostfull  in                 FIFO holds DEPTH-1 entries
//   fifo_wr_ack      in                 FIFO write accepted (observed only)
//   fifo_overflow    in                 FIFO write rejected
//   grant_id         out [IW-1:0]       current/last grant owner
//   grant_active     out                a grant is held
//   err_overflow     out                sticky, fifo_overflow seen
//   stat_beats       out [N_REQ*16-1:0] accepted beats per requester (stats build)
//
// FSM
//   state | meaning
//   IDLE  | no grant; pick next requester from rr_ptr (one bubble cycle)
//   BURST | grant held on grant_id; beats accepted while FIFO has room
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int FIFO_WIDTH = 16,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = idx_w(N_REQ),
  localparam int BW         = $clog2(MAX_BURST) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  output logic                        fifo_wr_en,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic [IW-1:0]               grant_id,
  output logic                        grant_active,
  output logic                        err_overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]     stat_beats
`endif
);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       grant_d;
  logic [IW-1:0]       rr_ptr, rr_ptr_d;
  logic [BW-1:0]       beat_cnt, beat_cnt_d;
  logic                can_write;
  logic                accept;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [FIFO_WIDTH-1:0] sel_data;
  logic [IW-1:0]       grant_next;

  // Write acknowledge is observed only; there is no retry path.
  logic unused_wr_ack;
  assign unused_wr_ack = fifo_wr_ack;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // When almostfull, a registered write already in flight will fill the
  // FIFO on this edge, so no further beat may be taken.
  assign can_write = !fifo_full && !(fifo_almostfull && fifo_wr_en);

  assign sel_data     = req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
  assign grant_next   = (grant_id == IW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
  assign grant_active = (state_q == BURST);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_id;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id] = can_write;
        accept              = req_valid[grant_id] && can_write;
        if (accept) begin
          beat_cnt_d = beat_cnt + 1'b1;
          if (req_last[grant_id] || (beat_cnt == BW'(MAX_BURST-1))) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      err_overflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id   <= grant_d;
      rr_ptr     <= rr_ptr_d;
      beat_cnt   <= beat_cnt_d;
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_data_in <= sel_data;
      end
      if (fifo_overflow) begin
        err_overflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (accept && (grant_id == IW'(i)) && (cnt != {STAT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign stat_beats[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
